commit_sched: RTL

- Commit scheduler for the head of the reorder buffer.
- Each cycle it inspects the CWIDTH oldest ROB slots and decides how many retire, driving ramt (ROB head advance) and amt (issue-queue head advance) to the head-pointer block in the same cycle.
- Sequences exception retirement: requests a redirect, waits for acknowledge, then holds a flush window before commit resumes.
- Sits between the ROB status arrays and the head-pointer/redirect logic.

---
 rtl/commit_sched_pkg.sv | 15 +
 rtl/commit_sched_if.sv | 39 +++
 rtl/commit_scan.sv | 42 ++++
 rtl/commit_sched.sv | 102 ++++++++++
 4 files changed

// File: rtl/commit_sched_pkg.sv
// Shared types for the ROB commit scheduler.
// Used by the head-pointer block as well.
package commit_sched_pkg;

  localparam int CWIDTH_DEF = 3;

  typedef enum logic [1:0] {
    CS_RUN   = 2'd0,
    CS_EXC   = 2'd1,
    CS_FLUSH = 2'd2
  } cstate_e;

  typedef logic [2:0] ccnt_t;

endpackage

// File: rtl/commit_sched_if.sv
// ROB-head status and head-pointer/redirect
// bundle seen by the commit scheduler.
interface commit_sched_if #(
  parameter int CWIDTH = 3,
  parameter int CNTW   = 32
);
  import commit_sched_pkg::*;

  logic              commit_en;
  logic [CWIDTH-1:0] head_v;
  logic [CWIDTH-1:0] head_done;
  logic [CWIDTH-1:0] head_exc;
  logic [CWIDTH-1:0] head_sync;
  logic [CWIDTH-1:0] head_iq;
  logic              exc_ack;
  ccnt_t             ramt;
  ccnt_t             amt;
  logic              exc_req;
  logic              flush;
  logic [1:0]        state;
  logic [CNTW-1:0]   commit_cnt;

  modport master (
    output commit_en, head_v, head_done,
    output head_exc, head_sync, head_iq,
    output exc_ack,
    input  ramt, amt, exc_req, flush,
    input  state, commit_cnt
  );

  modport slave (
    input  commit_en, head_v, head_done,
    input  head_exc, head_sync, head_iq,
    input  exc_ack,
    output ramt, amt, exc_req, flush,
    output state, commit_cnt
  );

endinterface

// File: rtl/commit_scan.sv
// Counts the leading committable ROB slots
// and the IQ entries they free.
module commit_scan
  import commit_sched_pkg::*;
#(
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              en,
  input  logic [CWIDTH-1:0] v,
  input  logic [CWIDTH-1:0] done,
  input  logic [CWIDTH-1:0] exc,
  input  logic [CWIDTH-1:0] sync,
  input  logic [CWIDTH-1:0] iq,
  output ccnt_t             ramt,
  output ccnt_t             amt,
  output logic              exc0
);

  logic ok;
  logic c;

  // in-order scan; first non-committable slot ends it
  always_comb begin
    ok   = en;
    c    = 1'b0;
    ramt = '0;
    amt  = '0;
    for (int i = 0; i < CWIDTH; i++) begin
      c = ok & v[i] & done[i] & ~exc[i];
      if (i != 0)
        c = c & ~sync[i] & ~sync[0];
      if (c) begin
        ramt = ramt + 3'd1;
        amt  = amt + {2'b00, iq[i]};
      end
      ok = c;
    end
  end

  assign exc0 = v[0] & done[0] & exc[0];

endmodule

// File: rtl/commit_sched.sv
// ROB-head commit scheduler: retire count,
// exception redirect and flush sequencing.
module commit_sched
  import commit_sched_pkg::*;
#(
  parameter int CWIDTH       = CWIDTH_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNTW         = 32
) (
  input logic           clk,
  input logic           rst,
  commit_sched_if.slave bus
);

  localparam logic [1:0] S_RUN   = CS_RUN;
  localparam logic [1:0] S_EXC   = CS_EXC;
  localparam logic [1:0] S_FLUSH = CS_FLUSH;

  localparam int FW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLOAD =
    FW'(FLUSH_CYCLES - 1);

  logic [1:0]      state_q;
  logic            exc_req_q;
  logic            flush_q;
  logic [FW-1:0]   fcnt_q;
  logic [CNTW-1:0] cnt_q;

  ccnt_t s_ramt;
  ccnt_t s_amt;
  logic  s_exc0;
  logic  run;
  logic  go_exc;

  commit_scan #(
    .CWIDTH (CWIDTH)
  ) u_scan (
    .en   (bus.commit_en),
    .v    (bus.head_v),
    .done (bus.head_done),
    .exc  (bus.head_exc),
    .sync (bus.head_sync),
    .iq   (bus.head_iq),
    .ramt (s_ramt),
    .amt  (s_amt),
    .exc0 (s_exc0)
  );

  assign run    = (state_q == S_RUN);
  assign go_exc = run & bus.commit_en & s_exc0;

  assign bus.ramt       = run ? s_ramt : '0;
  assign bus.amt        = run ? s_amt : '0;
  assign bus.exc_req    = exc_req_q;
  assign bus.flush      = flush_q;
  assign bus.state      = state_q;
  assign bus.commit_cnt = cnt_q;

  // FSM, flush timer and retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      exc_req_q <= 1'b0;
      flush_q   <= 1'b0;
      fcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + CNTW'(bus.ramt);
      case (state_q)
        S_RUN: begin
          if (go_exc) begin
            state_q   <= S_EXC;
            exc_req_q <= 1'b1;
          end
        end
        S_EXC: begin
          if (bus.exc_ack) begin
            state_q   <= S_FLUSH;
            exc_req_q <= 1'b0;
            flush_q   <= 1'b1;
            fcnt_q    <= FLOAD;
          end
        end
        S_FLUSH: begin
          if (fcnt_q == '0) begin
            state_q <= S_RUN;
            flush_q <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= S_RUN;
          exc_req_q <= 1'b0;
          flush_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
